// File: rtl/fifo_read_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fifo_read_arbiter
// Purpose  : Round-robin burst arbiter sharing one async-FIFO read port among
//            NUM_REQ read-domain consumers. Optional stall watchdog is built
//            when FIFO_RD_ARB_WDOG_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_read_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_BIT  = 4
`ifdef FIFO_RD_ARB_WDOG_EN
  , parameter int STALL_MAX = 16
`endif
) (
  input  logic                  r_clk,
  input  logic                  r_rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [BURST_BIT-1:0]  burst_len,
  input  logic                  fifo_flag_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_r_en,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  burst_done
`ifdef FIFO_RD_ARB_WDOG_EN
  , output logic                wdog_abort
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BURST   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  localparam logic [BURST_BIT:0] c_full_burst = {1'b1, {BURST_BIT{1'b0}}};
  localparam logic [BURST_BIT:0] c_one_beat   = (BURST_BIT+1)'(1);
  localparam logic [PTR_W-1:0]   c_last_idx   = PTR_W'(NUM_REQ - 1);

  logic [1:0]            r_state;
  logic [PTR_W-1:0]      r_rr_ptr;
  logic [PTR_W-1:0]      r_owner;
  logic [BURST_BIT:0]    r_beats;
  logic [NUM_REQ-1:0]    r_gnt;
  logic [NUM_REQ-1:0]    r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_burst_done;

  logic [PTR_W-1:0]      w_cand [NUM_REQ];
  logic                  w_pick_found;
  logic [PTR_W-1:0]      w_pick_idx;
  logic                  w_owner_req;
  logic                  w_rd_en;
  logic                  w_last_beat;
  logic                  w_abandon;
  logic                  w_wdog_trip;
  logic                  w_end_burst;

  // Candidate k is rr_ptr+k folded back into 0..NUM_REQ-1 (not a power-of-2 wrap)
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
    logic [PTR_W:0] w_sum;
    assign w_sum     = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
    assign w_cand[k] = (w_sum >= (PTR_W+1)'(NUM_REQ)) ?
                       PTR_W'(w_sum - (PTR_W+1)'(NUM_REQ)) : w_sum[PTR_W-1:0];
  end

  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[w_cand[k]]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = w_cand[k];
      end
    end
  end

  assign w_owner_req = req[r_owner];
  assign w_rd_en     = (r_state == S_BURST) & w_owner_req & ~fifo_flag_empty &
                       (r_beats != '0);
  assign w_last_beat = w_rd_en & (r_beats == c_one_beat);
  assign w_abandon   = (r_state == S_BURST) & ~w_owner_req;
  assign w_end_burst = w_abandon | w_last_beat | w_wdog_trip;

`ifdef FIFO_RD_ARB_WDOG_EN
  localparam int WD_W = $clog2(STALL_MAX + 1);
  localparam logic [WD_W-1:0] c_stall_last = WD_W'(STALL_MAX - 1);

  logic [WD_W-1:0] r_stall_cnt;
  logic            r_wdog_abort;

  assign w_wdog_trip = (r_state == S_BURST) & w_owner_req & fifo_flag_empty &
                       (r_stall_cnt == c_stall_last);

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_stall_cnt  <= '0;
      r_wdog_abort <= 1'b0;
    end else begin
      r_wdog_abort <= w_wdog_trip;
      if ((r_state != S_BURST) || w_rd_en)
        r_stall_cnt <= '0;
      else if (fifo_flag_empty)
        r_stall_cnt <= r_stall_cnt + WD_W'(1);
    end
  end

  assign wdog_abort = r_wdog_abort;
`else
  assign w_wdog_trip = 1'b0;
`endif

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_owner      <= '0;
      r_beats      <= '0;
      r_gnt        <= '0;
      r_burst_done <= 1'b0;
    end else begin
      r_burst_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_found && !fifo_flag_empty) begin
            r_state <= S_BURST;
            r_owner <= w_pick_idx;
            r_gnt   <= NUM_REQ'(1) << w_pick_idx;
            r_beats <= (burst_len == '0) ? c_full_burst : {1'b0, burst_len};
          end
        end
        S_BURST: begin
          if (w_rd_en)
            r_beats <= r_beats - c_one_beat;
          if (w_end_burst) begin
            r_state      <= S_RELEASE;
            r_burst_done <= 1'b1;
          end
        end
        S_RELEASE: begin
          r_state  <= S_IDLE;
          r_gnt    <= '0;
          r_rr_ptr <= (r_owner == c_last_idx) ? '0 : r_owner + PTR_W'(1);
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  // Read data is captured alongside its read enable so it lines up with the strobe
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_rd_valid <= '0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd_en ? r_gnt : '0;
      if (w_rd_en)
        r_rd_data <= fifo_rdata;
    end
  end

  assign fifo_r_en  = w_rd_en;
  assign gnt        = r_gnt;
  assign rd_valid   = r_rd_valid;
  assign rd_data    = r_rd_data;
  assign burst_done = r_burst_done;

endmodule
`default_nettype wire
